// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN streaming stages.
//   state_t        : pooling stage control states (ST_RUN, ST_DRAIN, ST_DONE)
//   sample_t       : signed sample at the default sample width
//   pool_out_size  : side of the pooled map for a given input side (floor SIZE/2)
// -----------------------------------------------------------------------------
package cnn_pkg;

  localparam int DEF_WIDTH_BIT = 16;

  typedef logic signed [DEF_WIDTH_BIT-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int pool_out_size(input int size);
    return size / 2;
  endfunction

endpackage

// File: rtl/maxpool2_stream_if.sv
// -----------------------------------------------------------------------------
// maxpool2_stream_if
// Valid/ready sample stream in, pooled stream out, plus the end-of-frame pulse.
//   in_valid/in_ready/in_data            : raster-order input samples
//   out_valid/out_ready/out_data/out_last : pooled samples, out_last on the final one
//   done                                  : one-cycle end-of-frame pulse
// Modports: master = upstream/downstream environment, slave = pooling stage.
// -----------------------------------------------------------------------------
interface maxpool2_stream_if #(
  parameter int WIDTH_BIT = 16
) ();

  logic                        in_valid;
  logic                        in_ready;
  logic signed [WIDTH_BIT-1:0] in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [WIDTH_BIT-1:0] out_data;
  logic                        out_last;
  logic                        done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, done
  );

endinterface

// File: rtl/pool_line_buf.sv
// -----------------------------------------------------------------------------
// pool_line_buf
// Half-width line buffer holding one pair result per output column.
// Synchronous write, combinational read.
//   clock   : rising-edge clock
//   i_we    : write enable
//   i_waddr : write address (col/2)
//   i_wdata : pair result to store
//   i_raddr : read address (col/2)
//   o_rdata : stored pair result
// -----------------------------------------------------------------------------
module pool_line_buf #(
  parameter int DEPTH = 159,
  parameter int DW    = 16,
  parameter int AW    = 8
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; every entry is written on an even row before
  // the following odd row reads it, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/maxpool2_stream.sv
// -----------------------------------------------------------------------------
// maxpool2_stream
// Streaming 2x2 / stride-2 pooling of a SIZE x SIZE raster-order map into a
// (SIZE/2) x (SIZE/2) raster-order map, using one half-width line buffer.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : maxpool2_stream_if.slave (input stream, pooled stream, done pulse)
// Build option: define MAXPOOL_AVG_EN for 2x2 average pooling (floor) instead
// of max pooling.
// -----------------------------------------------------------------------------
module maxpool2_stream
  import cnn_pkg::*;
#(
  parameter int SIZE      = 318,
  parameter int WIDTH_BIT = 16
) (
  input logic              clock,
  input logic              reset,
  maxpool2_stream_if.slave bus
);

  localparam int OUT    = pool_out_size(SIZE);
  localparam int CW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int AW     = (OUT > 1) ? $clog2(OUT) : 1;
  localparam bit IS_ODD = (SIZE % 2) != 0;
  localparam logic [CW-1:0] LAST_IDX = CW'(SIZE - 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(2 * OUT - 1);
`ifdef MAXPOOL_AVG_EN
  localparam int LBW = WIDTH_BIT + 1;
`else
  localparam int LBW = WIDTH_BIT;
`endif

  typedef logic signed [WIDTH_BIT-1:0] smp_t;

  function automatic smp_t smax(input smp_t a, input smp_t b);
    return (a > b) ? a : b;
  endfunction

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_row, r_col;
  smp_t          r_h, r_out_data;
  logic          r_out_valid, r_out_last;
  logic          w_in_ready, w_done, w_acc, w_in_win, w_we, w_load, w_frame_end;
  logic [AW-1:0] w_addr;
  logic [LBW-1:0] w_lb_wdata, w_lb_rdata;
  smp_t          w_pool;

  assign w_acc       = bus.in_valid && w_in_ready;
  // The last row/column of an odd map never completes a window.
  assign w_in_win    = !IS_ODD || ((r_row != LAST_IDX) && (r_col != LAST_IDX));
  assign w_we        = w_acc && w_in_win && r_col[0] && !r_row[0];
  assign w_load      = w_acc && w_in_win && r_col[0] && r_row[0];
  assign w_frame_end = w_acc && (r_row == LAST_IDX) && (r_col == LAST_IDX);
  assign w_addr      = AW'(r_col >> 1);

`ifdef MAXPOOL_AVG_EN
  logic signed [WIDTH_BIT:0]   w_pair_sum;
  logic signed [WIDTH_BIT+1:0] w_win_sum;

  always_comb begin
    w_pair_sum = {r_h[WIDTH_BIT-1], r_h} + {bus.in_data[WIDTH_BIT-1], bus.in_data};
    w_win_sum  = {w_lb_rdata[LBW-1], w_lb_rdata} + {w_pair_sum[WIDTH_BIT], w_pair_sum};
    w_lb_wdata = w_pair_sum;
    // Arithmetic shift floors the quotient toward minus infinity.
    w_pool     = smp_t'(w_win_sum >>> 2);
  end
`else
  always_comb begin
    w_lb_wdata = smax(r_h, bus.in_data);
    w_pool     = smax(smp_t'(w_lb_rdata), smp_t'(w_lb_wdata));
  end
`endif

  pool_line_buf #(
    .DEPTH (OUT),
    .DW    (LBW),
    .AW    (AW)
  ) u_line_buf (
    .clock   (clock),
    .i_we    (w_we),
    .i_waddr (w_addr),
    .i_wdata (w_lb_wdata),
    .i_raddr (w_addr),
    .o_rdata (w_lb_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_frame_end) w_state_nxt = ST_DRAIN;
      // Only the final pooled sample can still be pending here.
      ST_DRAIN: if (!r_out_valid || bus.out_ready) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no latch forms
  // for the states that do not mention it.
  always_comb begin
    w_in_ready = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      ST_RUN:  w_in_ready = !reset && (!r_out_valid || bus.out_ready);
      ST_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_row       <= '0;
      r_col       <= '0;
      r_h         <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (r_state == ST_DONE) begin
        r_row <= '0;
        r_col <= '0;
        r_h   <= '0;
      end else if (w_acc) begin
        if (!r_col[0]) r_h <= bus.in_data;
        if (r_col == LAST_IDX) begin
          r_col <= '0;
          r_row <= (r_row == LAST_IDX) ? '0 : r_row + CW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      // A load in the same cycle as an output handshake keeps out_valid high.
      if (w_load) begin
        r_out_data  <= w_pool;
        r_out_valid <= 1'b1;
        r_out_last  <= (r_row == WIN_LAST) && (r_col == WIN_LAST);
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.done      = w_done;

endmodule
